// File: rtl/fifo_to_axis_replay.sv
// Per-queue replay egress: pops {ctrl, data} words from a FWFT FIFO and emits AXI4-Stream packets.
// Define PCAP_REPLAY_IPG_EN to honour the recorded inter-packet gap held in each META word.
module fifo_to_axis_replay #(
    parameter int unsigned FIFO_DATA_WIDTH      = 72,
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned GAP_WIDTH            = 32,
    parameter logic [7:0]  SRC_PORT             = 8'h01
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sw_rst,
    input  logic                                 q_enable,
    input  logic [FIFO_DATA_WIDTH-1:0]           fifo_dout,
    input  logic                                 fifo_empty,
    output logic                                 fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic [31:0]                          pkt_count,
    output logic                                 len_err
);

    localparam int unsigned KeepWidth = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StMeta, StGap, StData} state_e;

    state_e                           state_q, state_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   tdata_q;
    logic [KeepWidth-1:0]             tkeep_q;
    logic                             tvalid_q;
    logic                             tlast_q;
    logic [31:0]                      tuser_q;
    logic [15:0]                      byte_cnt_q;
    logic [31:0]                      pkt_count_q;
    logic                             len_err_q;

    logic [KeepWidth-1:0]             in_ctrl;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   in_data;
    logic [KeepWidth-1:0]             in_keep;
    logic                             in_last;
    logic [15:0]                      byte_cnt_next;
    logic                             out_free;
    logic                             meta_pop;
    logic                             data_pop;
    logic                             unused_meta;

`ifdef PCAP_REPLAY_IPG_EN
    logic [GAP_WIDTH-1:0]             gap_cnt_q, gap_cnt_d;
    assign unused_meta = ^fifo_dout[31:24];
`else
    assign unused_meta = ^{fifo_dout[31:24], fifo_dout[32 +: GAP_WIDTH]};
`endif

    function automatic logic [15:0] popcount(input logic [KeepWidth-1:0] k);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < int'(KeepWidth); i++) begin
            c = c + 16'(k[i]);
        end
        return c;
    endfunction

    assign in_ctrl       = fifo_dout[FIFO_DATA_WIDTH-1 -: KeepWidth];
    assign in_data       = fifo_dout[C_M_AXIS_DATA_WIDTH-1:0];
    assign in_last       = |in_ctrl;
    assign in_keep       = in_last ? in_ctrl : {KeepWidth{1'b1}};
    assign byte_cnt_next = byte_cnt_q + popcount(in_keep);
    // Output register can accept a new beat this cycle.
    assign out_free      = !tvalid_q || m_axis_tready;
    assign meta_pop      = (state_q == StMeta) && fifo_rd_en;
    assign data_pop      = (state_q == StData) && fifo_rd_en;

    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
`ifdef PCAP_REPLAY_IPG_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                // Waiting on out_free keeps tuser steady until the previous tlast beat leaves.
                if (q_enable && !fifo_empty && out_free) begin
                    state_d = StMeta;
                end
            end
            StMeta: begin
                fifo_rd_en = 1'b1;
`ifdef PCAP_REPLAY_IPG_EN
                gap_cnt_d  = fifo_dout[32 +: GAP_WIDTH];
                state_d    = StGap;
`else
                state_d    = StData;
`endif
            end
            StGap: begin
`ifdef PCAP_REPLAY_IPG_EN
                if (gap_cnt_q == '0) begin
                    state_d = StData;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
`else
                state_d = StData;
`endif
            end
            StData: begin
                fifo_rd_en = !fifo_empty && out_free;
                if (fifo_rd_en && in_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (sw_rst) begin
            fifo_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
            byte_cnt_q  <= '0;
            pkt_count_q <= '0;
            len_err_q   <= 1'b0;
`ifdef PCAP_REPLAY_IPG_EN
            gap_cnt_q   <= '0;
`endif
        end else if (sw_rst) begin
            state_q     <= StIdle;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
            byte_cnt_q  <= '0;
            pkt_count_q <= '0;
            len_err_q   <= 1'b0;
`ifdef PCAP_REPLAY_IPG_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef PCAP_REPLAY_IPG_EN
            gap_cnt_q <= gap_cnt_d;
`endif
            if (data_pop) begin
                tvalid_q <= 1'b1;
                tdata_q  <= in_data;
                tkeep_q  <= in_keep;
                tlast_q  <= in_last;
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            if (meta_pop) begin
                tuser_q    <= {fifo_dout[23:16], SRC_PORT, fifo_dout[15:0]};
                byte_cnt_q <= '0;
            end else if (data_pop) begin
                byte_cnt_q <= in_last ? 16'd0 : byte_cnt_next;
            end

            if (data_pop && in_last && (byte_cnt_next != tuser_q[15:0])) begin
                len_err_q <= 1'b1;
            end

            if (tvalid_q && m_axis_tready && tlast_q) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, tuser_q};
    assign pkt_count     = pkt_count_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_fifo_to_axis_replay.sv
// Scoreboard bench for fifo_to_axis_replay: FIFO model, randomized sink, expected-beat queue.
module tb_fifo_to_axis_replay;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sw_rst;
    logic         q_enable;
    logic [71:0]  fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  pkt_count;
    logic         len_err;

    always #5 clk = ~clk;

    fifo_to_axis_replay dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rst        (sw_rst),
        .q_enable      (q_enable),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .len_err       (len_err)
    );

    typedef struct {
        logic [63:0]  data;
        logic [7:0]   keep;
        logic         last;
        logic [127:0] user;
        int           gap;
        bit           first;
    } beat_t;

    beat_t       exp_q[$];
    logic [71:0] fifo_q[$];
    int          idle_log[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_pkts;
    bit          exp_len_err;
    int          beats_seen = 0;
    int          rdy_mode;
    bit          starve;
    bit          rand_starve;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model and sink: inputs change on negedge, pops take effect at posedge.
    initial begin
        bit pop;
        bit stall_now;
        m_axis_tready = 1'b0;
        fifo_empty    = 1'b1;
        fifo_dout     = '0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = ~m_axis_tready;
            endcase
            stall_now  = starve || (rand_starve && ($urandom_range(0, 4) == 0));
            fifo_empty = (fifo_q.size() == 0) || stall_now;
            fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 72'd0;
            #1;
            pop = fifo_rd_en;
            @(posedge clk);
            if (pop && rst_n) begin
                chk("pop_nonempty", {127'd0, fifo_q.size() != 0}, 128'd1);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
        end
    end

    // Monitor: predicts the handshake at the coming posedge and checks it against the queue.
    initial begin
        beat_t e;
        beat_t held;
        bit    prev_stall = 0;
        bit    counting = 0;
        bit    idle_ok = 0;
        int    idle_cnt = 0;
        int    last_idle = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || sw_rst) begin
                prev_stall = 0;
                counting   = 0;
                idle_ok    = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {127'd0, m_axis_tvalid}, 128'd1);
                    chk("stall_hold", {55'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
                        {55'd0, held.data, held.keep, held.last});
                end
                if (m_axis_tvalid) begin
                    if (counting) begin
                        last_idle = idle_cnt;
                        idle_log.push_back(idle_cnt);
                        idle_ok  = 1;
                        counting = 0;
                    end
                    if (m_axis_tready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: got tdata %h with nothing expected",
                                     m_axis_tdata);
                        end else begin
                            e = exp_q.pop_front();
                            chk("tdata", {64'd0, m_axis_tdata}, {64'd0, e.data});
                            chk("tkeep", {120'd0, m_axis_tkeep}, {120'd0, e.keep});
                            chk("tlast", {127'd0, m_axis_tlast}, {127'd0, e.last});
                            chk("tuser", m_axis_tuser, e.user);
`ifdef PCAP_REPLAY_IPG_EN
                            if (e.first && idle_ok)
                                chk("ipg_min", {127'd0, last_idle >= e.gap}, 128'd1);
`endif
                            beats_seen++;
                        end
                        idle_ok    = 0;
                        prev_stall = 0;
                        if (m_axis_tlast) begin
                            counting = 1;
                            idle_cnt = 0;
                        end
                    end else begin
                        prev_stall = 1;
                        held.data  = m_axis_tdata;
                        held.keep  = m_axis_tkeep;
                        held.last  = m_axis_tlast;
                    end
                end else begin
                    prev_stall = 0;
                    if (counting) idle_cnt++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: META word, data words, and the beats the spec says they become.
    task automatic send_pkt(input int nwords, input int lastb, input int gap,
                            input logic [7:0] dst, input bit force_len, input logic [15:0] flen);
        logic [15:0] true_len;
        logic [15:0] len;
        logic [7:0]  ctrl;
        logic [63:0] d;
        beat_t       b;
        true_len = 16'((nwords - 1) * 8 + lastb);
        len      = force_len ? flen : true_len;
        fifo_q.push_back({8'($urandom), 32'(gap), 8'($urandom), dst, len});
        for (int i = 0; i < nwords; i++) begin
            d    = {$urandom, $urandom};
            ctrl = (i == nwords - 1) ? 8'((16'd1 << lastb) - 16'd1) : 8'h00;
            fifo_q.push_back({ctrl, d});
            b.data  = d;
            b.keep  = (ctrl == 8'h00) ? 8'hFF : ctrl;
            b.last  = (ctrl != 8'h00);
            b.user  = {96'd0, dst, 8'h01, len};
            b.gap   = gap;
            b.first = (i == 0);
            exp_q.push_back(b);
        end
        exp_pkts++;
        if (len != true_len) exp_len_err = 1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        cycles(3);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0 within %0d cycles",
                     exp_q.size(), budget);
        end
    endtask

    task automatic wait_beat(input int budget);
        int b0;
        int n;
        b0 = beats_seen;
        n  = 0;
        while (beats_seen == b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (beats_seen == b0) begin
            errors++;
            $display("FAIL beat_timeout: no beat within %0d cycles, required one", budget);
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_pkt_count"}, {96'd0, pkt_count}, {96'd0, 32'(exp_pkts)});
        chk({tag, "_len_err"}, {127'd0, len_err}, {127'd0, exp_len_err});
    endtask

    task automatic pulse_sw_rst();
        sw_rst = 1'b1;
        fifo_q.delete();
        cycles(1);
        sw_rst      = 1'b0;
        exp_pkts    = 0;
        exp_len_err = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_n = 1'b1; sw_rst = 1'b0; q_enable = 1'b0;
        rdy_mode = 0; starve = 0; rand_starve = 0;
        exp_pkts = 0; exp_len_err = 0;
        #1 rst_n = 1'b0;
        cycles(3);
        chk("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("rst_tdata", {64'd0, m_axis_tdata}, 128'd0);
        chk("rst_tuser", m_axis_tuser, 128'd0);
        chk("rst_rd_en", {127'd0, fifo_rd_en}, 128'd0);
        check_counters("rst");
        rst_n = 1'b1;
        q_enable = 1'b1;
        cycles(2);

        // Single packet: len 20, dst 4, beats FF, FF, 0F.
        send_pkt(3, 4, 0, 8'h04, 1'b1, 16'd20);
        wait_done(200);
        chk("single_tuser", {96'd0, m_axis_tuser[31:0]}, {96'd0, 32'h0401_0014});
        check_counters("single");

        // Backpressure toggling 1010.
        rdy_mode = 2;
        send_pkt(6, 8, 0, 8'h10, 1'b0, 16'd0);
        send_pkt(2, 1, 1, 8'h20, 1'b0, 16'd0);
        wait_done(400);
        check_counters("toggle");

        // Random traffic with random sink stalls and FIFO starvation.
        rdy_mode = 1;
        rand_starve = 1;
        for (int i = 0; i < 40; i++) begin
            send_pkt($urandom_range(1, 6), $urandom_range(1, 8), $urandom_range(0, 3),
                     8'($urandom), 1'b0, 16'd0);
        end
        wait_done(6000);
        check_counters("random");

        // Inter-packet gap: third packet carries gap 10, the second gap 0.
        rdy_mode = 0;
        rand_starve = 0;
        cycles(2);
        idle_log.delete();
        send_pkt(1, 8, 0, 8'h01, 1'b0, 16'd0);
        send_pkt(1, 8, 0, 8'h02, 1'b0, 16'd0);
        send_pkt(1, 8, 10, 8'h04, 1'b0, 16'd0);
        wait_done(300);
        chk("ipg_log_size", {96'd0, 32'(idle_log.size())}, {96'd0, 32'd3});
        d = (idle_log.size() == 3) ? idle_log[2] - idle_log[1] : -1;
`ifdef PCAP_REPLAY_IPG_EN
        chk("ipg_delta", {96'd0, 32'(d)}, {96'd0, 32'd10});
`else
        chk("ipg_delta", {96'd0, 32'(d)}, {96'd0, 32'd0});
`endif
        check_counters("gap");

        // Enable drop mid-packet plus 5 cycles of starvation.
        send_pkt(6, 8, 0, 8'h08, 1'b0, 16'd0);
        wait_beat(100);
        q_enable = 1'b0;
        starve = 1;
        cycles(5);
        starve = 0;
        wait_done(200);
        check_counters("enable");
        fifo_q.push_back({8'h00, 32'd0, 8'h00, 8'h01, 16'd8});
        fifo_q.push_back({8'hFF, 64'h1234});
        cycles(20);
        chk("disabled_no_pop", {96'd0, 32'(fifo_q.size())}, {96'd0, 32'd2});
        pulse_sw_rst();
        chk("swrst_pkt_count", {96'd0, pkt_count}, 128'd0);
        q_enable = 1'b1;
        cycles(2);

        // Length error is sticky across good packets until sw_rst.
        send_pkt(1, 8, 0, 8'h02, 1'b1, 16'd16);
        wait_done(100);
        check_counters("lenerr");
        send_pkt(2, 8, 0, 8'h02, 1'b0, 16'd0);
        send_pkt(1, 3, 0, 8'h02, 1'b0, 16'd0);
        wait_done(200);
        check_counters("lenerr_sticky");
        pulse_sw_rst();
        cycles(1);
        check_counters("lenerr_clear");

        // Asynchronous reset mid-packet.
        send_pkt(1, 8, 0, 8'h40, 1'b0, 16'd0);
        send_pkt(6, 8, 0, 8'h40, 1'b0, 16'd0);
        wait_beat(100);
        wait_beat(100);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("arst_tlast", {127'd0, m_axis_tlast}, 128'd0);
        chk("arst_tdata", {64'd0, m_axis_tdata}, 128'd0);
        chk("arst_tkeep", {120'd0, m_axis_tkeep}, 128'd0);
        chk("arst_tuser", m_axis_tuser, 128'd0);
        chk("arst_pkt_count", {96'd0, pkt_count}, 128'd0);
        chk("arst_rd_en", {127'd0, fifo_rd_en}, 128'd0);
        exp_q.delete();
        fifo_q.delete();
        exp_pkts = 0;
        exp_len_err = 0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        send_pkt(2, 5, 0, 8'h80, 1'b0, 16'd0);
        wait_done(200);
        check_counters("post_arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
